ej32_dstack: RTL and testbench

EJ32_DSTACK -- requirements
Module: ej32_dstack

---
 rtl/ej32_pkg.sv | 19 +
 rtl/bram_dp.sv | 29 ++
 rtl/ej32_dstack.sv | 170 +++++++++++++++++
 tb/tb_ej32_dstack.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared types and default sizes for the ej32 data stack.
package ej32_pkg;

  localparam int DSZ_DEFAULT   = 32;
  localparam int DEPTH_DEFAULT = 64;

  typedef enum logic [3:0] {
    sNOP  = 4'd0,
    sPUSH = 4'd1,
    sPOP  = 4'd2,
    sREPL = 4'd3,
    sALU  = 4'd4,
    sDUP  = 4'd5,
    sOVER = 4'd6,
    sSWAP = 4'd7,
    sPICK = 4'd8
  } ss_op_t;

endpackage

// File: rtl/bram_dp.sv
// Simple dual-port block RAM: one write port and one registered read port,
// both clocked on the falling edge so a read completes half a cycle early.
module bram_dp #(
  parameter int DW    = 32,
  parameter int AW    = 6,
  parameter int WORDS = 62
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  // Falling-edge write and registered read.
  always_ff @(negedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ej32_dstack.sv
// ej32 data stack: TOS/NOS in registers, deeper items in a falling-edge
// block RAM so refill reads land in time for the next rising edge.
module ej32_dstack
  import ej32_pkg::*;
#(
  parameter int DSZ   = DSZ_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int SSZ  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [3:0]     op,
  input  logic [DSZ-1:0] t_i,
  input  logic [SSZ-1:0] n_i,
  input  logic           clr_i,
  output logic [DSZ-1:0] t_o,
  output logic [DSZ-1:0] s_o,
  output logic [SSZ:0]   depth_o,
  output logic           empty_o,
  output logic           full_o,
  output logic           ovf_o,
  output logic           unf_o,
  output logic [SSZ:0]   hwm_o
);

  localparam logic [SSZ:0]   D_MAX = (SSZ+1)'(DEPTH);
  localparam logic [SSZ:0]   D_ONE = (SSZ+1)'(1);
  localparam logic [SSZ:0]   D_TWO = (SSZ+1)'(2);
  localparam logic [SSZ-1:0] A_ONE = SSZ'(1);
  localparam logic [SSZ-1:0] A_TWO = SSZ'(2);

  logic [DSZ-1:0] t_reg, t_next;
  logic [DSZ-1:0] s_reg, s_next;
  logic [SSZ:0]   depth_reg, depth_next;
  logic [SSZ:0]   hwm_reg, hwm_next;
  logic           ovf_reg, ovf_next;
  logic           unf_reg, unf_next;

  ss_op_t         op_s;
  logic [SSZ:0]   sp_wide;
  logic [SSZ-1:0] sp;
  logic           deep;
  logic           is_push;
  logic [SSZ:0]   need;
  logic [DSZ-1:0] push_val;
  logic           ovf_ev, unf_ev, legal;
  logic           we, re;
  logic [SSZ-1:0] raddr;
  logic [DSZ-1:0] rd_data;

  assign op_s = ss_op_t'(op);

  // Decode: operand requirements, push value and store port control.
  always_comb begin
    is_push  = 1'b0;
    need     = '0;
    push_val = t_i;
    sp_wide  = depth_reg - D_TWO;
    sp       = (depth_reg >= D_TWO) ? sp_wide[SSZ-1:0] : '0;
    deep     = (depth_reg > D_TWO);
    case (op_s)
      sPUSH: begin is_push = 1'b1; push_val = t_i; end
      sDUP:  begin is_push = 1'b1; need = D_ONE; push_val = t_reg; end
      sOVER: begin is_push = 1'b1; need = D_TWO; push_val = s_reg; end
      sPICK: begin
        is_push  = 1'b1;
        need     = {1'b0, n_i} + D_ONE;
        push_val = (n_i == '0) ? t_reg : (n_i == A_ONE) ? s_reg : rd_data;
      end
      sPOP:    need = D_ONE;
      sALU:    need = D_TWO;
      sSWAP:   need = D_TWO;
      default: need = '0;
    endcase
    ovf_ev = is_push && (depth_reg == D_MAX);
    unf_ev = !ovf_ev && (depth_reg < need);
    legal  = !ovf_ev && !unf_ev;
    // The two register-held items never touch the store.
    we     = en && !rst && legal && is_push && (depth_reg >= D_TWO);
    re     = en && !rst && legal &&
             ((((op_s == sPOP) || (op_s == sALU)) && deep) ||
              ((op_s == sPICK) && (n_i >= A_TWO)));
    raddr  = (op_s == sPICK) ? (sp + A_ONE - n_i) : (sp - A_ONE);
  end

  bram_dp #(
    .DW    (DSZ),
    .AW    (SSZ),
    .WORDS (DEPTH - 2)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (sp),
    .wdata (s_reg),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

  // Next-state for the register pair, depth and status flags.
  always_comb begin
    t_next     = t_reg;
    s_next     = s_reg;
    depth_next = depth_reg;
    if (legal) begin
      if (is_push) begin
        s_next     = t_reg;
        t_next     = push_val;
        depth_next = depth_reg + D_ONE;
      end else begin
        case (op_s)
          sPOP: begin
            t_next     = s_reg;
            s_next     = deep ? rd_data : '0;
            depth_next = depth_reg - D_ONE;
          end
          sALU: begin
            t_next     = t_i;
            s_next     = deep ? rd_data : '0;
            depth_next = depth_reg - D_ONE;
          end
          sREPL: begin
            t_next = t_i;
            if (depth_reg == '0) depth_next = D_ONE;
          end
          sSWAP: begin
            t_next = s_reg;
            s_next = t_reg;
          end
          default: ;
        endcase
      end
    end
    // A same-cycle event beats the clear.
    ovf_next = ovf_ev || (ovf_reg && !clr_i);
    unf_next = unf_ev || (unf_reg && !clr_i);
    if (clr_i || (depth_next > hwm_reg)) hwm_next = depth_next;
    else                                  hwm_next = hwm_reg;
  end

  // State register; reset wins over everything, en gates all updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg     <= '0;
      s_reg     <= '0;
      depth_reg <= '0;
      hwm_reg   <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else if (en) begin
      t_reg     <= t_next;
      s_reg     <= s_next;
      depth_reg <= depth_next;
      hwm_reg   <= hwm_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign t_o     = t_reg;
  assign s_o     = s_reg;
  assign depth_o = depth_reg;
  assign empty_o = (depth_reg == '0);
  assign full_o  = (depth_reg == D_MAX);
  assign ovf_o   = ovf_reg;
  assign unf_o   = unf_reg;
  assign hwm_o   = hwm_reg;

endmodule

// File: tb/tb_ej32_dstack.sv
// Bench for ej32_dstack: directed scenarios plus randomized ops, all checked
// against a queue-based stack model.
module tb_ej32_dstack;
  import ej32_pkg::*;

  localparam int DSZ   = 32;
  localparam int DEPTH = 64;
  localparam int SSZ   = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [3:0]     op = 4'd0;
  logic [DSZ-1:0] t_i = '0;
  logic [SSZ-1:0] n_i = '0;
  logic           clr_i = 1'b0;
  logic [DSZ-1:0] t_o, s_o;
  logic [SSZ:0]   depth_o, hwm_o;
  logic           empty_o, full_o, ovf_o, unf_o;

  int checks = 0;
  int failures = 0;

  // Reference model: stack items as a queue, top at the back.
  logic [DSZ-1:0] q[$];
  bit m_ovf, m_unf;
  int m_hwm;

  ej32_dstack #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .t_i(t_i), .n_i(n_i),
    .clr_i(clr_i), .t_o(t_o), .s_o(s_o), .depth_o(depth_o),
    .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o), .unf_o(unf_o),
    .hwm_o(hwm_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DSZ-1:0] m_t();
    return (q.size() > 0) ? q[q.size()-1] : '0;
  endfunction

  function automatic logic [DSZ-1:0] m_s();
    return (q.size() > 1) ? q[q.size()-2] : '0;
  endfunction

  task automatic model_step(input logic [3:0] o, input logic [DSZ-1:0] ti,
                            input int ni, input bit c, input bit e);
    int d;
    bit ov, un;
    logic [DSZ-1:0] a, b;
    if (!e) return;
    d = q.size();
    ov = 0; un = 0;
    case (o)
      sPUSH: if (d == DEPTH) ov = 1; else q.push_back(ti);
      sPOP:  if (d < 1) un = 1; else void'(q.pop_back());
      sREPL: if (d == 0) q.push_back(ti); else q[d-1] = ti;
      sALU:  if (d < 2) un = 1;
             else begin void'(q.pop_back()); void'(q.pop_back()); q.push_back(ti); end
      sDUP:  if (d == DEPTH) ov = 1; else if (d < 1) un = 1; else q.push_back(q[d-1]);
      sOVER: if (d == DEPTH) ov = 1; else if (d < 2) un = 1; else q.push_back(q[d-2]);
      sSWAP: if (d < 2) un = 1;
             else begin a = q[d-1]; b = q[d-2]; q[d-1] = b; q[d-2] = a; end
      sPICK: if (d == DEPTH) ov = 1; else if (d < ni + 1) un = 1; else q.push_back(q[d-1-ni]);
      default: ;
    endcase
    m_ovf = ov || (m_ovf && !c);
    m_unf = un || (m_unf && !c);
    if (c || q.size() > m_hwm) m_hwm = q.size();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".t"},     64'(t_o),     64'(m_t()));
    check({tag, ".s"},     64'(s_o),     64'(m_s()));
    check({tag, ".depth"}, 64'(depth_o), 64'(q.size()));
    check({tag, ".empty"}, 64'(empty_o), 64'(q.size() == 0));
    check({tag, ".full"},  64'(full_o),  64'(q.size() == DEPTH));
    check({tag, ".ovf"},   64'(ovf_o),   64'(m_ovf));
    check({tag, ".unf"},   64'(unf_o),   64'(m_unf));
    check({tag, ".hwm"},   64'(hwm_o),   64'(m_hwm));
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [DSZ-1:0] ti,
                       input int ni, input bit c, input bit e);
    op = o; t_i = ti; n_i = SSZ'(ni); clr_i = c; en = e;
    @(posedge clk);
    model_step(o, ti, ni, c, e);
    #1;
    $display("%s op=%0d t_i=%0h n=%0d en=%0b clr=%0b -> t=%0h s=%0h depth=%0d ovf=%0b unf=%0b hwm=%0d",
             tag, o, ti, ni, e, c, t_o, s_o, depth_o, ovf_o, unf_o, hwm_o);
    check_all(tag);
    en = 1'b0; clr_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; en = 1'b1; op = sPUSH; t_i = 32'hDEAD;
    @(posedge clk);
    q.delete(); m_ovf = 0; m_unf = 0; m_hwm = 0;
    #1;
    rst = 1'b0; en = 1'b0;
    $display("%s reset -> t=%0h s=%0h depth=%0d", tag, t_o, s_o, depth_o);
    check_all(tag);
  endtask

  initial begin
    logic [3:0] ro;
    int bias;
    m_ovf = 0; m_unf = 0; m_hwm = 0;

    do_reset("rst0");

    // Basic push/pop.
    do_op("v40", sPUSH, 1, 0, 0, 1);
    do_op("v40", sPUSH, 2, 0, 0, 1);
    do_op("v40", sPUSH, 3, 0, 0, 1);
    check("v40_t3", 64'(t_o), 64'd3);
    check("v40_s2", 64'(s_o), 64'd2);
    do_op("v40", sPOP, 0, 0, 0, 1);
    check("v40_pop_t", 64'(t_o), 64'd2);
    check("v40_pop_d", 64'(depth_o), 64'd2);

    // Fill, overflow, drain.
    do_reset("rst1");
    for (int i = 1; i <= DEPTH; i++) do_op("v41fill", sPUSH, i, 0, 0, 1);
    do_op("v41ovf", sPUSH, 99, 0, 0, 1);
    check("v41_ovf", 64'(ovf_o), 64'd1);
    check("v41_depth", 64'(depth_o), 64'(DEPTH));
    check("v41_t", 64'(t_o), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("v41_seq", 64'(t_o), 64'(DEPTH - i));
      do_op("v41pop", sPOP, 0, 0, 0, 1);
    end
    check("v41_empty", 64'(empty_o), 64'd1);

    // Underflow, clear, REPL on empty.
    do_op("v42pop", sPOP, 0, 0, 0, 1);
    check("v42_unf", 64'(unf_o), 64'd1);
    do_op("v42clr", sNOP, 0, 0, 1, 1);
    check("v42_unf_clr", 64'(unf_o), 64'd0);
    do_op("v42repl", sREPL, 7, 0, 0, 1);
    check("v42_t", 64'(t_o), 64'd7);
    check("v42_d", 64'(depth_o), 64'd1);

    // PICK / SWAP / OVER.
    do_reset("rst2");
    do_op("v43", sPUSH, 10, 0, 0, 1);
    do_op("v43", sPUSH, 20, 0, 0, 1);
    do_op("v43", sPUSH, 30, 0, 0, 1);
    do_op("v43", sPUSH, 40, 0, 0, 1);
    do_op("v43pick", sPICK, 0, 3, 0, 1);
    check("v43_pick_t", 64'(t_o), 64'd10);
    check("v43_pick_d", 64'(depth_o), 64'd5);
    do_op("v43swap", sSWAP, 0, 0, 0, 1);
    check("v43_swap_t", 64'(t_o), 64'd40);
    check("v43_swap_s", 64'(s_o), 64'd10);
    do_op("v43over", sOVER, 0, 0, 0, 1);
    check("v43_over_t", 64'(t_o), 64'd10);

    // ALU at depth 2.
    do_reset("rst3");
    do_op("v44", sPUSH, 5, 0, 0, 1);
    do_op("v44", sPUSH, 6, 0, 0, 1);
    do_op("v44alu", sALU, 11, 0, 0, 1);
    check("v44_t", 64'(t_o), 64'd11);
    check("v44_s", 64'(s_o), 64'd0);
    check("v44_d", 64'(depth_o), 64'd1);
    check("v44_hwm", 64'(hwm_o), 64'd2);

    // Reset in the middle of a push burst.
    for (int i = 0; i < 5; i++) do_op("v45burst", sPUSH, 100 + i, 0, 0, 1);
    do_reset("v45rst");
    check("v45_t0", 64'(t_o), 64'd0);
    check("v45_d0", 64'(depth_o), 64'd0);
    do_op("v45push", sPUSH, 4, 0, 0, 1);
    check("v45_t", 64'(t_o), 64'd4);
    check("v45_d", 64'(depth_o), 64'd1);

    // Randomized ops: push-biased phase, pop-biased phase, then unbiased.
    for (int i = 0; i < 2400; i++) begin
      bias = (i < 800) ? 0 : (i < 1600) ? 1 : 2;
      if (bias == 0 && $urandom_range(0, 99) < 55) begin
        case ($urandom_range(0, 3))
          0: ro = sPUSH; 1: ro = sDUP; 2: ro = sOVER; default: ro = sPICK;
        endcase
      end else if (bias == 1 && $urandom_range(0, 99) < 55) begin
        ro = ($urandom_range(0, 1) == 0) ? sPOP : sALU;
      end else begin
        ro = 4'($urandom_range(0, 15));
      end
      do_op("rnd", ro, $urandom(),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 6)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
